// File: rtl/display_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: blanked digit slots, page arbitration
// (manual or auto-alternating), per-frame snapshot and leading-zero suppression.
module display_scan_scheduler #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int AUTO_FRAMES  = 250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        switch,
    input  logic        auto_en,
    input  logic [15:0] freq_bcd,
    input  logic [15:0] duty_bcd,
    input  logic [3:0]  freq_dp,
    input  logic [3:0]  duty_dp,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp,
    output logic        page,
    output logic        frame_tick
);

    localparam int SW = $clog2(PRESCALE);
    localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(PRESCALE - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    // slot_cnt/dig_idx/state describe the cycle that the next edge will present;
    // the output registers therefore always match the current position.
    state_t        state;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    dig_idx;
    logic [FW-1:0] frame_cnt;
    logic [15:0]   snap;
    logic [3:0]    dp_snap;

    logic          arb_edge;
    logic          next_page;
    logic [FW-1:0] next_frame_cnt;
    logic [15:0]   next_snap;
    logic [3:0]    next_dp_snap;

    function automatic logic [3:0] disp_nibble(input logic [15:0] bcd, input logic [1:0] k);
        logic [3:0] nib;
        logic       lead;
        nib  = 4'h0;
        lead = 1'b0;
        case (k)
            2'd3: begin nib = bcd[15:12]; lead = (bcd[15:12] == 4'h0); end
            2'd2: begin nib = bcd[11:8];  lead = (bcd[15:8]  == 8'h00); end
            2'd1: begin nib = bcd[7:4];   lead = (bcd[15:4]  == 12'h000); end
            default: begin nib = bcd[3:0]; lead = 1'b0; end
        endcase
        return (nib > 4'd9 || lead) ? 4'hF : nib;
    endfunction

    // Arbitration happens on the edge that presents the first DRIVE cycle of digit 0.
    assign arb_edge = (dig_idx == 2'd0) && (slot_cnt == BLANK_END);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        next_page      = page;
        next_frame_cnt = frame_cnt;
        next_snap      = snap;
        next_dp_snap   = dp_snap;
        if (arb_edge) begin
            if (auto_en) begin
                if (frame_cnt == FRAME_LAST) begin
                    next_page      = ~page;
                    next_frame_cnt = '0;
                end else begin
                    next_frame_cnt = frame_cnt + 1'b1;
                end
            end else begin
                next_page      = switch;
                next_frame_cnt = '0;
            end
            next_snap    = next_page ? duty_bcd : freq_bcd;
            next_dp_snap = next_page ? duty_dp  : freq_dp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= BLANK;
            slot_cnt   <= '0;
            dig_idx    <= 2'd0;
            frame_cnt  <= '0;
            snap       <= 16'h0000;
            dp_snap    <= 4'h0;
            page       <= 1'b0;
            an         <= 4'b1111;
            digit      <= 4'hF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
            if (slot_cnt == SLOT_LAST) begin
                dig_idx <= dig_idx + 2'd1;
            end

            page      <= next_page;
            frame_cnt <= next_frame_cnt;
            snap      <= next_snap;
            dp_snap   <= next_dp_snap;

            frame_tick <= (dig_idx == 2'd3) && (slot_cnt == SLOT_LAST);

            case (state)
                BLANK: begin
                    an    <= 4'b1111;
                    digit <= 4'hF;
                    dp    <= 1'b1;
                    if (slot_cnt == BLANK_LAST) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    an    <= ~(4'b0001 << dig_idx);
                    digit <= disp_nibble(next_snap, dig_idx);
                    dp    <= ~next_dp_snap[dig_idx];
                    if (slot_cnt == SLOT_LAST) begin
                        state <= BLANK;
                    end
                end
                default: begin
                    state <= BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Self-checking bench for display_scan_scheduler: per-cycle reference model of the
// scan/arbitration rules, table-driven display vectors and hand-written corner sequences.
module tb_display_scan_scheduler;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int AUTO     = 3;
    localparam int FRAME    = 4 * PRESCALE;

    logic        clock = 1'b0;
    logic        reset;
    logic        switch;
    logic        auto_en;
    logic [15:0] freq_bcd;
    logic [15:0] duty_bcd;
    logic [3:0]  freq_dp;
    logic [3:0]  duty_dp;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        dp;
    logic        page;
    logic        frame_tick;

    display_scan_scheduler #(
        .PRESCALE    (PRESCALE),
        .BLANK_CYCLES(BLANK),
        .AUTO_FRAMES (AUTO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .switch    (switch),
        .auto_en   (auto_en),
        .freq_bcd  (freq_bcd),
        .duty_bcd  (duty_bcd),
        .freq_dp   (freq_dp),
        .duty_dp   (duty_dp),
        .digit     (digit),
        .an        (an),
        .dp        (dp),
        .page      (page),
        .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: cycle index since reset release plus per-frame page state.
    int          cyc;
    int          last;
    logic        m_page;
    int          m_fcnt;
    logic [15:0] m_snap;
    logic [3:0]  m_dpsnap;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpm;
        logic [15:0] exp_digits;
        logic [3:0]  exp_dp_low;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Displayed value of digit k: invalid nibbles and digits above the highest nonzero one go blank.
    function automatic logic [3:0] shown(input logic [15:0] v, input int k);
        int         hi;
        logic [3:0] n;
        hi = 0;
        n  = v[k*4 +: 4];
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] != 4'h0) hi = i;
        end
        if (n > 4'd9) return 4'hF;
        if (k > hi) return 4'hF;
        return n;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    task automatic model_reset();
        cyc      = 0;
        last     = -1;
        m_page   = 1'b0;
        m_fcnt   = 0;
        m_snap   = 16'h0000;
        m_dpsnap = 4'h0;
    endtask

    // Advance one clock and compare every output against the model for that cycle.
    task automatic step();
        int         slot;
        int         k;
        logic [3:0] e_an;
        logic [3:0] e_digit;
        logic       e_dp;
        logic       e_tick;
        slot = cyc % PRESCALE;
        k    = (cyc / PRESCALE) % 4;
        if (cyc % FRAME == BLANK) begin
            if (auto_en) begin
                if (m_fcnt == AUTO - 1) begin
                    m_page = ~m_page;
                    m_fcnt = 0;
                end else begin
                    m_fcnt++;
                end
            end else begin
                m_page = switch;
                m_fcnt = 0;
            end
            m_snap   = m_page ? duty_bcd : freq_bcd;
            m_dpsnap = m_page ? duty_dp : freq_dp;
        end
        if (slot < BLANK) begin
            e_an    = 4'b1111;
            e_digit = 4'hF;
            e_dp    = 1'b1;
        end else begin
            e_an    = ~(4'b0001 << k);
            e_digit = shown(m_snap, k);
            e_dp    = ~m_dpsnap[k];
        end
        e_tick = (cyc % FRAME == FRAME - 1) ? 1'b1 : 1'b0;
        @(posedge clock);
        #1;
        check($sformatf("cycle %0d {an,digit,dp,page,tick}", cyc),
              {21'd0, an, digit, dp, page, frame_tick},
              {21'd0, e_an, e_digit, e_dp, m_page, e_tick});
        last = cyc;
        cyc++;
    endtask

    task automatic run_to(input int phase);
        while (cyc % FRAME != phase) step();
    endtask

    vec_t vecs[9];

    initial begin
        logic [15:0] got;
        logic [3:0]  dpl;
        logic [5:0]  pages;
        int          c;
        int          f;

        vecs[0] = '{16'h1234, 4'b0000, 16'h1234, 4'b0000};
        vecs[1] = '{16'h0050, 4'b0000, 16'hFF50, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, 16'hFFF0, 4'b0000};
        vecs[3] = '{16'h12A4, 4'b0100, 16'h12F4, 4'b0100};
        vecs[4] = '{16'h0A05, 4'b0001, 16'hFF05, 4'b0001};
        vecs[5] = '{16'h0009, 4'b1000, 16'hFFF9, 4'b1000};
        vecs[6] = '{16'h1000, 4'b1111, 16'h1000, 4'b1111};
        vecs[7] = '{16'hF0F0, 4'b0000, 16'hF0F0, 4'b0000};
        vecs[8] = '{16'h9900, 4'b0010, 16'h9900, 4'b0010};

        reset    = 1'b1;
        switch   = 1'b0;
        auto_en  = 1'b0;
        freq_bcd = 16'h1234;
        duty_bcd = 16'h0000;
        freq_dp  = 4'b0000;
        duty_dp  = 4'b0000;
        #2 reset = 1'b0;
        #3;
        check("reset values {an,digit,dp,page,tick}", {21'd0, an, digit, dp, page, frame_tick},
              {21'd0, 4'b1111, 4'hF, 1'b1, 1'b0, 1'b0});
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Basic scan with explicit expectations for the first frame.
        for (int i = 0; i <= FRAME; i++) begin
            step();
            if (last < 2) check($sformatf("basic blank an c%0d", last), {28'd0, an}, 32'hF);
            if (last == 2)  check("basic d0", {24'd0, an, digit}, {24'd0, 4'b1110, 4'h4});
            if (last == 10) check("basic d1", {24'd0, an, digit}, {24'd0, 4'b1101, 4'h3});
            if (last == 18) check("basic d2", {24'd0, an, digit}, {24'd0, 4'b1011, 4'h2});
            if (last == 26) check("basic d3", {24'd0, an, digit}, {24'd0, 4'b0111, 4'h1});
            if (last == 30) check("basic tick low c30", {31'd0, frame_tick}, 32'd0);
            if (last == 31) check("basic tick high c31", {31'd0, frame_tick}, 32'd1);
            if (last == 32) check("basic restart blank", {28'd0, an}, 32'hF);
        end

        // Table-driven display vectors on the frequency page.
        foreach (vecs[i]) begin
            freq_bcd = vecs[i].bcd;
            freq_dp  = vecs[i].dpm;
            switch   = 1'b0;
            run_to(0);
            got = 16'h0000;
            dpl = 4'h0;
            for (int j = 0; j < FRAME; j++) begin
                c = cyc;
                step();
                if (c % PRESCALE == 5) begin
                    got[((c / PRESCALE) % 4) * 4 +: 4] = digit;
                    dpl[(c / PRESCALE) % 4] = ~dp;
                end
            end
            check($sformatf("vec%0d digits", i), {16'd0, got}, {16'd0, vecs[i].exp_digits});
            check($sformatf("vec%0d dp", i), {28'd0, dpl}, {28'd0, vecs[i].exp_dp_low});
        end

        // Manual page switch during digit-1 DRIVE must not disturb the current frame.
        freq_bcd = 16'h1234;
        freq_dp  = 4'b0000;
        duty_bcd = 16'h0789;
        duty_dp  = 4'b0010;
        run_to(0);
        run_to(12);
        switch = 1'b1;
        run_to(26);
        step();
        check("switch same frame", {27'd0, page, digit}, {27'd0, 1'b0, 4'h1});
        run_to(2);
        step();
        check("switch next frame d0", {26'd0, page, digit, dp}, {26'd0, 1'b1, 4'h9, 1'b1});
        run_to(10);
        step();
        check("switch next frame d1", {26'd0, page, digit, dp}, {26'd0, 1'b1, 4'h8, 1'b0});

        // Auto alternation with switch toggling randomly.
        run_to(20);
        auto_en = 1'b1;
        pages   = 6'd0;
        f       = 0;
        while (f < 6) begin
            switch = 1'($urandom_range(0, 1));
            c = cyc;
            step();
            if (c % FRAME == 2) begin
                pages[f] = page;
                f++;
            end
        end
        check("auto page sequence", {26'd0, pages}, {26'd0, 6'b100011});
        auto_en = 1'b0;
        switch  = 1'b0;
        run_to(20);
        step();
        check("auto drop same frame", {31'd0, page}, 32'd1);
        run_to(2);
        step();
        check("auto drop follows switch", {31'd0, page}, 32'd0);

        // Randomised stimulus against the model.
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) freq_bcd = rand_bcd();
            if ($urandom_range(0, 15) == 0) duty_bcd = rand_bcd();
            if ($urandom_range(0, 15) == 0) freq_dp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) duty_dp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) switch = ~switch;
            if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
            step();
        end

        // Asynchronous reset in the middle of a DRIVE slot.
        auto_en  = 1'b0;
        switch   = 1'b1;
        freq_bcd = 16'h0042;
        duty_bcd = 16'h0567;
        run_to(0);
        run_to(13);
        check("pre-reset page", {31'd0, page}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset outputs", {25'd0, an, digit, dp, page, frame_tick},
              {25'd0, 4'b1111, 4'hF, 1'b1, 1'b0, 1'b0});
        @(posedge clock);
        #1;
        check("held reset outputs", {25'd0, an, digit, dp, page, frame_tick},
              {25'd0, 4'b1111, 4'hF, 1'b1, 1'b0, 1'b0});
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            if (last < 2) check($sformatf("restart blank c%0d", last), {28'd0, an}, 32'hF);
            if (last == 2) check("restart d0", {23'd0, an, digit, page}, {23'd0, 4'b1110, 4'h7, 1'b1});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
